// File: rtl/instr_loader_if.sv
// Byte-stream, instruction-memory and pipeline-control signals of the instruction loader.
// The loader takes the master side and the surrounding system takes the slave side.
interface instr_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  i_haltsignal;
  logic [DATA_WIDTH-1:0] o_instruccion;
  logic [DATA_WIDTH-1:0] o_address;
  logic                  o_loading;
  logic                  o_pipe_reset;
  logic                  o_pc_enable;
  logic                  o_busy;
  logic                  o_load_error;
  logic                  o_program_loaded;

  modport master (
    input  i_rx_data, i_rx_valid, i_haltsignal,
    output o_instruccion, o_address, o_loading, o_pipe_reset,
           o_pc_enable, o_busy, o_load_error, o_program_loaded
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_haltsignal,
    input  o_instruccion, o_address, o_loading, o_pipe_reset,
           o_pc_enable, o_busy, o_load_error, o_program_loaded
  );
endinterface

// File: rtl/instr_loader.sv
// Serial program loader: assembles received bytes into instruction words, writes them to
// instruction memory, then runs or single-steps the pipeline on command bytes.
module instr_loader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         SIZEOP     = 6,
  parameter int         MEM_DEPTH  = 32,
  parameter logic [7:0] CMD_LOAD   = 8'h4C,
  parameter logic [7:0] CMD_RUN    = 8'h52,
  parameter logic [7:0] CMD_STEP   = 8'h53
) (
  input  logic           i_clock,
  input  logic           i_reset,
  instr_loader_if.master bus
);

  localparam int                IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MEM_DEPTH - 1);
  localparam logic [SIZEOP-1:0] HALT_OP  = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_STEP  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]            state_q,     state_d;
  logic [1:0]            byte_cnt_q,  byte_cnt_d;
  logic [IDX_W-1:0]      index_q,     index_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [DATA_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] instr_q,     instr_d;
  logic                  load_err_q,  load_err_d;
  logic                  loaded_q,    loaded_d;

  logic is_load;
  logic is_run;
  logic is_step;

  assign is_load = bus.i_rx_valid && (bus.i_rx_data == CMD_LOAD);
  assign is_run  = bus.i_rx_valid && (bus.i_rx_data == CMD_RUN);
  assign is_step = bus.i_rx_valid && (bus.i_rx_data == CMD_STEP);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    index_d    = index_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    load_err_d = load_err_q;
    loaded_d   = loaded_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (is_load) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          index_d    = '0;
          shift_d    = '0;
          load_err_d = 1'b0;
          loaded_d   = 1'b0;
        end else if (is_run && loaded_q) begin
          state_d = S_START;
        end else if (is_step && loaded_q && (state_q == S_IDLE)) begin
          state_d = S_STEP;
        end
      end

      S_LOAD: begin
        if (bus.i_rx_valid) begin
          shift_d    = {shift_q[DATA_WIDTH-9:0], bus.i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Latch the word and its index so the memory side sees them stable through WRITE and after.
            state_d = S_WRITE;
            addr_d  = DATA_WIDTH'(index_q);
            instr_d = shift_d;
          end
        end
      end

      S_WRITE: begin
        if (instr_q[DATA_WIDTH-1 -: SIZEOP] == HALT_OP) begin
          state_d  = S_IDLE;
          loaded_d = 1'b1;
        end else if (index_q == LAST_IDX) begin
          state_d    = S_IDLE;
          load_err_d = 1'b1;
        end else begin
          state_d    = S_LOAD;
          index_d    = index_q + 1'b1;
          byte_cnt_d = '0;
        end
      end

      S_START: state_d = S_RUN;

      S_RUN: begin
        if (bus.i_haltsignal) begin
          state_d = S_DONE;
        end
      end

      S_STEP: state_d = bus.i_haltsignal ? S_DONE : S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      index_q    <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      instr_q    <= '0;
      load_err_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      index_q    <= index_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      load_err_q <= load_err_d;
      loaded_q   <= loaded_d;
    end
  end

  // The halt flag gates the PC enable combinationally so the pipeline stops in the halt cycle.
  assign bus.o_loading        = (state_q == S_WRITE);
  assign bus.o_pipe_reset     = (state_q == S_START);
  assign bus.o_pc_enable      = ((state_q == S_RUN) || (state_q == S_STEP)) && !bus.i_haltsignal;
  assign bus.o_busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.o_address        = addr_q;
  assign bus.o_instruccion    = instr_q;
  assign bus.o_load_error     = load_err_q;
  assign bus.o_program_loaded = loaded_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: load, overflow, run, step, halt and mid-load reset scenarios.
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_loader_if #(.DATA_WIDTH(32)) lif ();

  instr_loader #(
    .DATA_WIDTH (32),
    .SIZEOP     (6),
    .MEM_DEPTH  (32),
    .CMD_LOAD   (8'h4C),
    .CMD_RUN    (8'h52),
    .CMD_STEP   (8'h53)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (lif)
  );

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0;
  int          pr_cnt = 0;
  int          en_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (lif.o_loading) begin
      wr_cnt++;
      wr_addr.push_back(lif.o_address);
      wr_data.push_back(lif.o_instruccion);
    end
    if (lif.o_pipe_reset) pr_cnt++;
    if (lif.o_pc_enable)  en_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #2;
    lif.i_rx_data  = b;
    lif.i_rx_valid = 1'b1;
    @(posedge clk);
    #2;
    lif.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int p0;
    int e0;

    rst_n            = 1'b0;
    lif.i_rx_data    = 8'h00;
    lif.i_rx_valid   = 1'b0;
    lif.i_haltsignal = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",     32'(lif.o_busy),           32'd0);
    check("rst_loading",  32'(lif.o_loading),        32'd0);
    check("rst_pipe_rst", 32'(lif.o_pipe_reset),     32'd0);
    check("rst_pc_en",    32'(lif.o_pc_enable),      32'd0);
    check("rst_err",      32'(lif.o_load_error),     32'd0);
    check("rst_loaded",   32'(lif.o_program_loaded), 32'd0);
    check("rst_addr",     lif.o_address,             32'd0);
    check("rst_instr",    lif.o_instruccion,         32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_cycles(2);

    // Run/step with no program are ignored
    p0 = pr_cnt;
    e0 = en_cnt;
    send_byte(8'h52);
    send_byte(8'h53);
    idle_cycles(3);
    @(negedge clk);
    check("noprog_pipe_rst", 32'(pr_cnt - p0), 32'd0);
    check("noprog_pc_en",    32'(en_cnt - e0), 32'd0);
    check("noprog_busy",     32'(lif.o_busy),  32'd0);

    // Two-word load ending on HALT
    w0 = wr_cnt;
    send_byte(8'h4C);
    send_word(32'h0000_0001);
    send_word(32'hFC00_0000);
    idle_cycles(3);
    @(negedge clk);
    check("load2_count",   32'(wr_cnt - w0),         32'd2);
    check("load2_addr0",   wr_addr[w0],              32'd0);
    check("load2_data0",   wr_data[w0],              32'h0000_0001);
    check("load2_addr1",   wr_addr[w0+1],            32'd1);
    check("load2_data1",   wr_data[w0+1],            32'hFC00_0000);
    check("load2_loaded",  32'(lif.o_program_loaded), 32'd1);
    check("load2_err",     32'(lif.o_load_error),    32'd0);
    check("load2_loading", 32'(lif.o_loading),       32'd0);
    check("load2_addr_hold",  lif.o_address,         32'd1);
    check("load2_instr_hold", lif.o_instruccion,     32'hFC00_0000);

    // Run until halt
    p0 = pr_cnt;
    e0 = en_cnt;
    send_byte(8'h52);
    @(negedge clk);
    check("start_pipe_rst", 32'(lif.o_pipe_reset), 32'd1);
    check("start_pc_en",    32'(lif.o_pc_enable),  32'd0);
    check("start_busy",     32'(lif.o_busy),       32'd1);
    repeat (5) @(posedge clk);
    #2;
    lif.i_haltsignal = 1'b1;
    @(negedge clk);
    check("halt_pc_gated", 32'(lif.o_pc_enable), 32'd0);
    check("halt_busy_run", 32'(lif.o_busy),      32'd1);
    @(negedge clk);
    check("done_busy",      32'(lif.o_busy),    32'd0);
    check("run_pc_en_cnt",  32'(en_cnt - e0),   32'd4);
    check("run_pipe_rst",   32'(pr_cnt - p0),   32'd1);

    // DONE ignores step, restarts on run
    lif.i_haltsignal = 1'b0;
    e0 = en_cnt;
    send_byte(8'h53);
    idle_cycles(2);
    @(negedge clk);
    check("done_step_ignored", 32'(en_cnt - e0), 32'd0);
    check("done_step_busy",    32'(lif.o_busy),  32'd0);
    p0 = pr_cnt;
    send_byte(8'h52);
    idle_cycles(2);
    @(negedge clk);
    check("restart_pipe_rst", 32'(pr_cnt - p0), 32'd1);
    check("restart_busy",     32'(lif.o_busy),  32'd1);
    lif.i_haltsignal = 1'b1;
    idle_cycles(2);
    @(negedge clk);
    check("restart_done", 32'(lif.o_busy), 32'd0);

    // Reload from DONE, then single-step
    lif.i_haltsignal = 1'b0;
    send_byte(8'h4C);
    send_word(32'h0000_0001);
    send_word(32'hFC00_0000);
    idle_cycles(3);
    @(negedge clk);
    check("reload_loaded", 32'(lif.o_program_loaded), 32'd1);
    e0 = en_cnt;
    send_byte(8'h53);
    @(negedge clk);
    check("step1_pc_en", 32'(lif.o_pc_enable), 32'd1);
    check("step1_busy",  32'(lif.o_busy),      32'd1);
    send_byte(8'h53);
    send_byte(8'h53);
    idle_cycles(2);
    @(negedge clk);
    check("step3_count", 32'(en_cnt - e0), 32'd3);
    check("step3_idle",  32'(lif.o_busy),  32'd0);
    lif.i_haltsignal = 1'b1;
    e0 = en_cnt;
    send_byte(8'h53);
    @(negedge clk);
    check("step_halt_pc_en", 32'(lif.o_pc_enable), 32'd0);
    idle_cycles(2);
    @(negedge clk);
    check("step_halt_count", 32'(en_cnt - e0), 32'd0);
    check("step_halt_busy",  32'(lif.o_busy),  32'd0);
    lif.i_haltsignal = 1'b0;

    // 32 words without HALT overflow the memory
    w0 = wr_cnt;
    send_byte(8'h4C);
    for (int i = 0; i < 32; i++) begin
      send_word({24'h0, 8'(i)});
    end
    idle_cycles(3);
    @(negedge clk);
    check("ovf_count",  32'(wr_cnt - w0),          32'd32);
    check("ovf_addr0",  wr_addr[w0],               32'd0);
    check("ovf_addr16", wr_addr[w0+16],            32'd16);
    check("ovf_data16", wr_data[w0+16],            32'h0000_0010);
    check("ovf_addr31", wr_addr[w0+31],            32'd31);
    check("ovf_data31", wr_data[w0+31],            32'h0000_001F);
    check("ovf_err",    32'(lif.o_load_error),     32'd1);
    check("ovf_loaded", 32'(lif.o_program_loaded), 32'd0);
    check("ovf_busy",   32'(lif.o_busy),           32'd0);
    send_word(32'h0102_0304);
    idle_cycles(3);
    @(negedge clk);
    check("ovf_extra_ignored", 32'(wr_cnt - w0),      32'd32);
    check("ovf_err_sticky",    32'(lif.o_load_error), 32'd1);
    p0 = pr_cnt;
    send_byte(8'h52);
    idle_cycles(3);
    @(negedge clk);
    check("ovf_run_ignored", 32'(pr_cnt - p0), 32'd0);

    // Reset in the middle of a word
    send_byte(8'h4C);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    check("midload_busy", 32'(lif.o_busy), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   32'(lif.o_busy),           32'd0);
    check("midrst_addr",   lif.o_address,             32'd0);
    check("midrst_instr",  lif.o_instruccion,         32'd0);
    check("midrst_err",    32'(lif.o_load_error),     32'd0);
    check("midrst_loaded", 32'(lif.o_program_loaded), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    w0 = wr_cnt;
    send_byte(8'h4C);
    send_word(32'hAABB_CCDD);
    idle_cycles(3);
    @(negedge clk);
    check("postrst_count",  32'(wr_cnt - w0),          32'd1);
    check("postrst_addr",   wr_addr[w0],               32'd0);
    check("postrst_data",   wr_data[w0],               32'hAABB_CCDD);
    check("postrst_busy",   32'(lif.o_busy),           32'd1);
    check("postrst_loaded", 32'(lif.o_program_loaded), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
